// File: rtl/fact_pkg.sv
// Shared types and constants for the memory-mapped factorial engine.
package fact_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        CALC = 1'b1
    } state_t;

    localparam logic [1:0] ADDR_N    = 2'b00;
    localparam logic [1:0] ADDR_GO   = 2'b01;
    localparam logic [1:0] ADDR_STAT = 2'b10;
    localparam logic [1:0] ADDR_RES  = 2'b11;

    localparam int STAT_DONE = 0;
    localparam int STAT_ERR  = 1;

    localparam int DEFAULT_MAX_N = 12;

endpackage

// File: rtl/fact_dp.sv
// Iterative factorial datapath: running product and down-counting multiplier.
module fact_dp #(
    parameter int WIDTH = 32,
    parameter int NW    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    input  logic [NW-1:0]    load_val,
    output logic [WIDTH-1:0] prod,
    output logic             last
);

    logic [NW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prod <= '0;
            cnt  <= '0;
        end else if (load) begin
            prod <= WIDTH'(1);
            cnt  <= load_val;
        end else if (step) begin
            // Truncation is safe: MAX_N keeps every legal product below 2^WIDTH.
            prod <= prod * WIDTH'(cnt);
            cnt  <= cnt - NW'(1);
        end
    end

    assign last = (cnt <= NW'(1));

endmodule

// File: rtl/fact_core.sv
// Factorial engine: bus registers, sequencing FSM and read-data mux.
//   state | meaning
//   IDLE  | accepts n writes and go starts; results/status held
//   CALC  | one multiply per cycle until the counter reaches 1
module fact_core
    import fact_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int NW    = 4,
    parameter int MAX_N = DEFAULT_MAX_N
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             WE1,
    input  logic             WE2,
    input  logic [1:0]       RdSel,
    input  logic [WIDTH-1:0] WD,
    output logic [WIDTH-1:0] RD
);

    localparam logic [NW-1:0] MAX_N_V = NW'(MAX_N);

    state_t           state;
    logic [NW-1:0]    n_r;
    logic             go_r;
    logic             done_r;
    logic             err_r;
    logic [WIDTH-1:0] res_r;

    logic [WIDTH-1:0] prod;
    logic             dp_last;
    logic             start_req;
    logic             n_illegal;
    logic             dp_load;
    logic             dp_step;

    wire unused_wd = &{1'b0, WD[WIDTH-1:NW]};

    assign start_req = (state == IDLE) && WE2 && WD[0];
    assign n_illegal = (n_r > MAX_N_V);
    assign dp_load   = start_req && !n_illegal;
    assign dp_step   = (state == CALC) && !dp_last;

    fact_dp #(
        .WIDTH (WIDTH),
        .NW    (NW)
    ) u_dp (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (dp_load),
        .step     (dp_step),
        .load_val (n_r),
        .prod     (prod),
        .last     (dp_last)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            n_r    <= '0;
            go_r   <= 1'b0;
            done_r <= 1'b0;
            err_r  <= 1'b0;
            res_r  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_req) begin
                        if (n_illegal) begin
                            err_r  <= 1'b1;
                            done_r <= 1'b1;
                            res_r  <= '0;
                        end else begin
                            go_r   <= 1'b1;
                            done_r <= 1'b0;
                            err_r  <= 1'b0;
                            state  <= CALC;
                        end
                    // A go write owns the cycle even when it does not start.
                    end else if (WE1 && !WE2) begin
                        n_r <= WD[NW-1:0];
                    end
                end
                CALC: begin
                    if (dp_last) begin
                        res_r  <= prod;
                        done_r <= 1'b1;
                        go_r   <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        RD = '0;
        case (RdSel)
            ADDR_N:    RD = WIDTH'(n_r);
            ADDR_GO:   RD = WIDTH'(go_r);
            ADDR_STAT: begin
                RD[STAT_DONE] = done_r;
                RD[STAT_ERR]  = err_r;
            end
            ADDR_RES:  RD = res_r;
            default:   RD = '0;
        endcase
    end

endmodule

// File: tb/tb_fact_core.sv
// Scoreboard bench for fact_core: stimulus queues expected reads, monitor compares.
module tb_fact_core;

    localparam int WIDTH = 32;

    logic             clk;
    logic             rst_n;
    logic             WE1;
    logic             WE2;
    logic [1:0]       RdSel;
    logic [WIDTH-1:0] WD;
    logic [WIDTH-1:0] RD;

    typedef struct {
        logic [WIDTH-1:0] exp;
        string            name;
    } exp_t;

    exp_t exp_q[$];
    logic chk_en;
    int   n_checks;
    int   n_fail;

    fact_core #(.WIDTH(WIDTH), .NW(4), .MAX_N(12)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .WE1   (WE1),
        .WE2   (WE2),
        .RdSel (RdSel),
        .WD    (WD),
        .RD    (RD)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: read data is sampled mid-cycle, away from the rising edge.
    always @(negedge clk) begin
        if (chk_en) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL no_expected_entry: RD=0x%08h with empty scoreboard", RD);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (RD !== e.exp) begin
                    n_fail++;
                    $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", e.name, RD, e.exp, $time);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Check one register during the current cycle; consumes one clock.
    task automatic rd_check(input logic [1:0] sel, input logic [WIDTH-1:0] exp, input string name);
        exp_t e;
        e.exp  = exp;
        e.name = name;
        RdSel  = sel;
        exp_q.push_back(e);
        chk_en = 1'b1;
        tick();
        chk_en = 1'b0;
    endtask

    // Write n then go=1; returns just after the start edge E0.
    task automatic do_start(input int n);
        WE1 = 1'b1;
        WD  = WIDTH'(n);
        tick();
        WE1 = 1'b0;
        WE2 = 1'b1;
        WD  = 32'd1;
        tick();
        WE2 = 1'b0;
        WD  = '0;
    endtask

    task automatic busy_window(input int cycles, input string name);
        for (int k = 0; k < cycles; k++) rd_check(2'b01, 32'd1, name);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        chk_en   = 1'b0;
        rst_n    = 1'b0;
        WE1      = 1'b0;
        WE2      = 1'b0;
        RdSel    = 2'b00;
        WD       = '0;
        tick();
        tick();
        rst_n = 1'b1;

        rd_check(2'b00, 32'd0, "reset_n");
        rd_check(2'b01, 32'd0, "reset_go");
        rd_check(2'b10, 32'd0, "reset_stat");
        rd_check(2'b11, 32'd0, "reset_res");

        // n = 5
        do_start(5);
        busy_window(5, "n5_busy");
        rd_check(2'b10, 32'd1, "n5_stat");
        rd_check(2'b11, 32'd120, "n5_res");
        rd_check(2'b01, 32'd0, "n5_go_after");

        // go write with WD[0]=0 does nothing
        WE2 = 1'b1;
        WD  = 32'h2;
        tick();
        WE2 = 1'b0;
        rd_check(2'b01, 32'd0, "go0_go");
        rd_check(2'b10, 32'd1, "go0_stat");

        // n = 12 (largest legal)
        do_start(12);
        busy_window(12, "n12_busy");
        rd_check(2'b10, 32'd1, "n12_stat");
        rd_check(2'b11, 32'h1C8CFC00, "n12_res");

        // n = 13 (error start)
        do_start(13);
        rd_check(2'b10, 32'd3, "n13_stat");
        rd_check(2'b11, 32'd0, "n13_res");
        rd_check(2'b01, 32'd0, "n13_go");
        rd_check(2'b00, 32'd13, "n13_n");

        // n = 0 and n = 1
        do_start(0);
        busy_window(1, "n0_busy");
        rd_check(2'b10, 32'd1, "n0_stat");
        rd_check(2'b11, 32'd1, "n0_res");
        do_start(1);
        busy_window(1, "n1_busy");
        rd_check(2'b10, 32'd1, "n1_stat");
        rd_check(2'b11, 32'd1, "n1_res");

        // n = 6 with writes during CALC
        do_start(6);
        WE1 = 1'b1;
        WD  = 32'd3;
        rd_check(2'b01, 32'd1, "n6_busy0");
        WE1 = 1'b0;
        rd_check(2'b00, 32'd6, "n6_n_held");
        WE2 = 1'b1;
        WD  = 32'd1;
        rd_check(2'b01, 32'd1, "n6_busy2");
        WE2 = 1'b0;
        WD  = '0;
        busy_window(3, "n6_busy3");
        rd_check(2'b10, 32'd1, "n6_stat");
        rd_check(2'b11, 32'd720, "n6_res");
        do_start(3);
        busy_window(3, "n3_busy");
        rd_check(2'b11, 32'd6, "n3_res");

        // reset at E0+3 of n = 10
        do_start(10);
        busy_window(2, "n10_busy");
        rst_n = 1'b0;
        rd_check(2'b01, 32'd1, "n10_busy_pre_rst");
        rst_n = 1'b1;
        rd_check(2'b00, 32'd0, "rst_mid_n");
        rd_check(2'b01, 32'd0, "rst_mid_go");
        rd_check(2'b10, 32'd0, "rst_mid_stat");
        rd_check(2'b11, 32'd0, "rst_mid_res");
        tick();
        tick();
        rd_check(2'b10, 32'd0, "rst_mid_stat_later");
        do_start(4);
        busy_window(4, "n4_busy");
        rd_check(2'b10, 32'd1, "n4_stat");
        rd_check(2'b11, 32'd24, "n4_res");

        tick();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
